// File: rtl/mpmc11_req_seq.sv
// Single-channel request sequencer for mpmc11: one read/write request in,
// MIG-style app command/write-data/read-return handshakes out, timeout abort.
package mpmc11_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE_DATA = 3'd1,
        SET_CMD    = 3'd2,
        WAIT_RD    = 3'd3,
        ACK        = 3'd4
    } mpmc11_state_t;
endpackage

module mpmc11_req_seq
    import mpmc11_pkg::*;
#(
    parameter int AWID = 32,
    parameter int DWID = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [AWID-1:0]     adr,
    input  logic [DWID-1:0]     dat,
    input  logic [DWID/8-1:0]   sel,
    output logic                ack,
    output logic                err,
    output logic [DWID-1:0]     rdat,
    output logic                busy,
    output mpmc11_state_t       state,
    output mpmc11_state_t       prev_state,
    input  logic [15:0]         to_cnt,
    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [AWID-1:0]     app_addr,
    input  logic                app_rdy,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DWID-1:0]     app_wdf_data,
    output logic [DWID/8-1:0]   app_wdf_mask,
    input  logic                app_wdf_rdy,
    input  logic [DWID-1:0]     app_rd_data,
    input  logic                app_rd_data_valid
);

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    mpmc11_state_t      state_n;
    logic               we_q, we_n;
    logic               ack_n, err_n, en_n, wren_n;
    logic [2:0]         cmd_n;
    logic [AWID-1:0]    addr_n;
    logic [DWID-1:0]    data_n, rdat_n;
    logic [DWID/8-1:0]  mask_n;
    logic               timeout;

    // Only bit 9 of the stall count matters here.
    logic unused_to;
    assign unused_to = ^{to_cnt[15:10], to_cnt[8:0]};

    assign timeout = to_cnt[9] &&
                     (state == WRITE_DATA || state == SET_CMD || state == WAIT_RD);

    always_comb begin
        state_n = state;
        we_n    = we_q;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        en_n    = app_en;
        cmd_n   = app_cmd;
        addr_n  = app_addr;
        wren_n  = app_wdf_wren;
        data_n  = app_wdf_data;
        mask_n  = app_wdf_mask;
        rdat_n  = rdat;

        // Abort takes priority over any handshake finishing this cycle.
        if (timeout) begin
            en_n    = 1'b0;
            wren_n  = 1'b0;
            ack_n   = 1'b1;
            err_n   = 1'b1;
            state_n = ACK;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_n   = we;
                        addr_n = adr;
                        data_n = dat;
                        mask_n = ~sel;
                        if (we) begin
                            wren_n  = 1'b1;
                            state_n = WRITE_DATA;
                        end else begin
                            en_n    = 1'b1;
                            cmd_n   = CMD_RD;
                            state_n = SET_CMD;
                        end
                    end
                end
                WRITE_DATA: begin
                    if (app_wdf_rdy) begin
                        wren_n  = 1'b0;
                        en_n    = 1'b1;
                        cmd_n   = CMD_WR;
                        state_n = SET_CMD;
                    end
                end
                SET_CMD: begin
                    if (app_rdy) begin
                        en_n = 1'b0;
                        if (we_q) begin
                            ack_n   = 1'b1;
                            state_n = ACK;
                        end else begin
                            state_n = WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (app_rd_data_valid) begin
                        rdat_n  = app_rd_data;
                        ack_n   = 1'b1;
                        state_n = ACK;
                    end
                end
                ACK:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_state   <= IDLE;
            busy         <= 1'b0;
            we_q         <= 1'b0;
            ack          <= 1'b0;
            err          <= 1'b0;
            rdat         <= '0;
            app_en       <= 1'b0;
            app_cmd      <= '0;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
        end else begin
            state        <= state_n;
            prev_state   <= state;
            busy         <= (state_n != IDLE);
            we_q         <= we_n;
            ack          <= ack_n;
            err          <= err_n;
            rdat         <= rdat_n;
            app_en       <= en_n;
            app_cmd      <= cmd_n;
            app_addr     <= addr_n;
            app_wdf_wren <= wren_n;
            app_wdf_end  <= wren_n;
            app_wdf_data <= data_n;
            app_wdf_mask <= mask_n;
        end
    end

endmodule

// File: doc/mpmc11_req_seq.md
Name: mpmc11_req_seq

Overview:
Single-channel request sequencer for the mpmc11 controller. It accepts one read or write request from a port and drives the MIG-style app interface, returning read data or a write acknowledge. It produces `state` and `prev_state` for the timeout counter. It consumes `to_cnt` back from that counter and uses it to abort hung transactions.

Parameters:
AWID, 32, byte address width.
DWID, 128, data width; must be a multiple of 8.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous reset, active-low.
req  in  1  request strobe; sampled only in IDLE.
we  in  1  1 = write, 0 = read.
adr  in  AWID  request byte address.
dat  in  DWID  write data.
sel  in  DWID/8  byte enables, 1 = write byte.
ack  out  1  one-cycle completion pulse.
err  out  1  valid with ack; 1 = aborted by timeout.
rdat  out  DWID  read data; valid with ack on a read.
busy  out  1  high whenever state != IDLE.
state  out  mpmc11_state_t  current sequencer state.
prev_state  out  mpmc11_state_t  state of the previous cycle.
to_cnt  in  16  stall count from the timeout counter.
app_en  out  1  command valid.
app_cmd  out  3  3'b000 write, 3'b001 read.
app_addr  out  AWID  command address.
app_rdy  in  1  command accepted when app_en and app_rdy are both high.
app_wdf_wren  out  1  write data valid.
app_wdf_end  out  1  equals app_wdf_wren (single beat).
app_wdf_data  out  DWID  write data.
app_wdf_mask  out  DWID/8  ~sel; 1 = byte masked.
app_wdf_rdy  in  1  write data accepted when wren and rdy are both high.
app_rd_data  in  DWID  read return data.
app_rd_data_valid  in  1  read return strobe.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE and prev_state=IDLE.
  - app_en, app_wdf_wren, ack, err and busy are 0.
  - rdat=0; app_cmd, app_addr and app_wdf_* are 0.
- Reset mid-transaction drops app_en and app_wdf_wren the next edge; no ack is issued.
- prev_state <= state every non-reset cycle.
- States used: IDLE, WRITE_DATA, SET_CMD, WAIT_RD, ACK.
- IDLE:
  - If req=1: latch we, adr, dat and sel.
  - If we=1, go to WRITE_DATA and assert app_wdf_wren/end in the same edge.
  - If we=0, go to SET_CMD with app_en=1 and app_cmd=001.
- WRITE_DATA: hold wren/data/mask stable until app_wdf_rdy=1 is sampled. Then deassert wren and go to SET_CMD with app_en=1 and app_cmd=000.
- SET_CMD: hold app_en, app_cmd and app_addr stable until app_rdy=1 is sampled. Then deassert app_en.
  - Write: go to ACK with ack=1, err=0.
  - Read: go to WAIT_RD.
- WAIT_RD: on app_rd_data_valid=1, rdat <= app_rd_data and go to ACK with ack=1, err=0.
- ACK: ack is high exactly one cycle, then return to IDLE. req is ignored in ACK; the earliest new acceptance is the cycle after re-entering IDLE.
- app_rd_data_valid outside WAIT_RD is ignored.
- Timeout:
  - Applies in WRITE_DATA, SET_CMD or WAIT_RD when to_cnt[9]=1 is sampled.
  - Timeout wins over a handshake completing in the same cycle.
  - Response: deassert app_en and app_wdf_wren, go to ACK with ack=1, err=1; rdat is unchanged.
- ack and err fall to 0 on the cycle after ACK.
- busy = (state != IDLE); it is registered alongside state.
- Latency, with app_rdy and app_wdf_rdy tied high:
  - Write: ack 3 cycles after the req edge.
  - Read: ack 1 cycle after the cycle in which app_rd_data_valid is sampled.

Test Plan:
- Write, ready tied high: req=1, we=1, adr=32'h100, sel=16'h00FF at cycle 0.
  - Cycle 1: wren=1, mask=16'hFF00.
  - Cycle 2: app_en=1, app_cmd=000, app_addr=32'h100.
  - Cycle 3: ack=1, err=0.
  - Cycle 4: state=IDLE.
- Read: req=1, we=0, adr=32'h240 at cycle 0; app_rd_data_valid=1 with data 128'hDEADBEEF at cycle 5.
  - Cycle 1: app_en=1, app_cmd=001.
  - Cycle 6: ack=1, rdat=128'hDEADBEEF.
- Backpressure: app_rdy low for 10 cycles in SET_CMD → app_en, app_cmd and app_addr stay constant for those 10 cycles; accept on cycle 11; ack follows 1 cycle later.
- Timeout: bench drives to_cnt=16'h0200 while in WAIT_RD → next cycle ack=1, err=1, app_en=0, rdat unchanged; IDLE the cycle after.
- Timeout race: app_rdy=1 in the same cycle to_cnt[9]=1 in SET_CMD → err=1 path is taken.
- Reset mid-write: rst_n=0 during WRITE_DATA → next edge state=IDLE, prev_state=IDLE, wren=0, ack=0; a new req is accepted on the first cycle after rst_n=1.
